// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_controller_pkg: command, state and CPU error types shared by the run controller.
package cpu_run_controller_pkg;
  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_HALT  = 2'd3
  } ctrl_cmd_e;
  typedef enum logic [2:0] {
    RESETTING = 3'd0,
    HALTED    = 3'd1,
    RUNNING   = 3'd2,
    STEPPING  = 3'd3,
    STOPPED   = 3'd4,
    FAULT     = 3'd5
  } ctrl_state_e;
  typedef struct packed {
    logic decoder;
    logic alu;
  } cpu_error_t;
  function automatic logic [7:0] step_load(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction
endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: host command handshake, CPU control/status and debug outputs.
interface cpu_run_controller_if #(parameter int CNT_W = 32);
  import cpu_run_controller_pkg::*;
  logic             cmd_valid;
  logic             cmd_ready;
  ctrl_cmd_e        cmd;
  logic [7:0]       step_count;
  logic             cpu_stop;
  cpu_error_t       cpu_error;
  logic             cpu_clk_en;
  logic             cpu_reset;
  ctrl_state_e      state;
  cpu_error_t       error_latched;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    output cmd_valid, cmd, step_count, cpu_stop, cpu_error,
    input  cmd_ready, cpu_clk_en, cpu_reset, state, error_latched, cycle_count
  );
  modport slave (
    input  cmd_valid, cmd, step_count, cpu_stop, cpu_error,
    output cmd_ready, cpu_clk_en, cpu_reset, state, error_latched, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller_saturating_counter.sv
// saturating_counter: up-counter that holds at all-ones, with synchronous clear taking priority.
module saturating_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk) begin
    r_count <= i_clear ? '0 : (i_inc && !(&r_count)) ? r_count + 1'b1 : r_count;
  end
  assign o_count = r_count;
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences CPU reset/run/step/halt by gating its clock enable.
// Define CPU_CYCLE_COUNTER_EN to build the saturating cycle_count; otherwise it is tied to 0.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                clk,
  input logic                reset,
  cpu_run_controller_if.slave bus
);
  ctrl_state_e r_state;
  ctrl_state_e w_nxt_state;
  logic [3:0]  r_rst_cnt;
  logic [3:0]  w_nxt_rst_cnt;
  logic [7:0]  r_step_cnt;
  logic [7:0]  w_nxt_step_cnt;
  cpu_error_t  r_err;
  cpu_error_t  w_nxt_err;
  logic        w_acc;
  logic        w_active;
  logic        w_run_en;
  assign w_acc    = bus.cmd_valid && bus.cmd_ready;
  assign w_active = (r_state == RUNNING) || (r_state == STEPPING);
  assign w_run_en = !bus.cpu_stop && !(|bus.cpu_error);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RESETTING;
      r_rst_cnt  <= 4'(RESET_CYCLES);
      r_step_cnt <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_rst_cnt  <= w_nxt_rst_cnt;
      r_step_cnt <= w_nxt_step_cnt;
      r_err      <= w_nxt_err;
    end
  end
  // A visible stop or error outranks any command in the active states, including CMD_RESET.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_rst_cnt  = r_rst_cnt;
    w_nxt_step_cnt = r_step_cnt;
    w_nxt_err      = r_err;
    unique case (r_state)
      RESETTING: begin
        w_nxt_rst_cnt = r_rst_cnt - 4'd1;
        if (r_rst_cnt <= 4'd1) w_nxt_state = HALTED;
      end
      HALTED: begin
        if (w_acc && bus.cmd == CMD_RUN) w_nxt_state = RUNNING;
        if (w_acc && bus.cmd == CMD_STEP) begin
          w_nxt_state    = STEPPING;
          w_nxt_step_cnt = step_load(bus.step_count);
        end
      end
      RUNNING, STEPPING: begin
        if (|bus.cpu_error) begin
          w_nxt_state = FAULT;
          w_nxt_err   = bus.cpu_error;
        end else if (bus.cpu_stop) begin
          w_nxt_state = STOPPED;
        end else if (w_acc && bus.cmd == CMD_HALT) begin
          w_nxt_state = HALTED;
        end else if (r_state == STEPPING) begin
          w_nxt_step_cnt = r_step_cnt - 8'd1;
          if (r_step_cnt <= 8'd1) w_nxt_state = HALTED;
        end
      end
      default: ;
    endcase
    if (w_acc && bus.cmd == CMD_RESET && !(w_active && !w_run_en)) begin
      w_nxt_state    = RESETTING;
      w_nxt_rst_cnt  = 4'(RESET_CYCLES);
      w_nxt_step_cnt = '0;
      w_nxt_err      = '0;
    end
  end
  assign bus.cpu_reset     = reset || (r_state == RESETTING);
  assign bus.cmd_ready     = !bus.cpu_reset;
  assign bus.cpu_clk_en    = bus.cpu_reset || (w_active && w_run_en);
  assign bus.state         = r_state;
  assign bus.error_latched = r_err;
`ifdef CPU_CYCLE_COUNTER_EN
  logic w_enter_rst;
  assign w_enter_rst = reset || (w_nxt_state == RESETTING && r_state != RESETTING);
  saturating_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .i_clear (w_enter_rst),
    .i_inc   (bus.cpu_clk_en && !bus.cpu_reset),
    .o_count (bus.cycle_count)
  );
`else
  assign bus.cycle_count = '0;
`endif
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: scoreboard bench; expectations queued with each stimulus, popped at DUT response.
module tb_cpu_run_controller;
  import cpu_run_controller_pkg::*;
  localparam int CNT_W = 32;
`ifdef CPU_CYCLE_COUNTER_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif
  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int edges = 0;
  exp_t sb[$];
  cpu_run_controller_if #(.CNT_W(CNT_W)) bus ();
  cpu_run_controller #(.RESET_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // CPU edges that the coming posedge will deliver, sampled well clear of both clock edges
  always @(negedge clk) begin
    #2;
    if (bus.cpu_clk_en && !bus.cpu_reset) edges++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endfunction
  task automatic pop_chk(input logic [63:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "sb_underflow";
      e.v = ~got;
    end else begin
      e = sb.pop_front();
    end
    chk(e.tag, got, e.v);
  endtask
  function automatic logic [63:0] cc(input int v);
    return CC_EN ? 64'(v) : 64'd0;
  endfunction
  task automatic issue(input ctrl_cmd_e c, input logic [7:0] n);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd = c;
    bus.step_count = n;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_state(input ctrl_state_e s);
    for (int i = 0; i < 400 && bus.state != s; i++) @(negedge clk);
    if (bus.state != s) chk("wait_state_timeout", bus.state, s);
  endtask
  task automatic wait_edges(input int base, input int n);
    for (int i = 0; i < 400 && (edges - base) < n; i++) @(negedge clk);
    if ((edges - base) < n) chk("wait_edges_timeout", edges - base, n);
  endtask
  initial begin
    int base;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd = CMD_RESET;
    bus.step_count = 8'd0;
    bus.cpu_stop = 1'b0;
    bus.cpu_error = '0;
    push("rst_cyc_cpu_reset", 1);
    push("rst_cyc_clk_en", 1);
    push("rst_cyc_ready", 0);
    @(negedge clk);
    pop_chk(bus.cpu_reset);
    pop_chk(bus.cpu_clk_en);
    pop_chk(bus.cmd_ready);
    push("rst_len", 2);
    push("rst_state", HALTED);
    push("rst_ready", 1);
    push("rst_count", 0);
    reset = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 20 && bus.cpu_reset; i++) begin
      n++;
      @(negedge clk);
      #1;
    end
    pop_chk(n);
    pop_chk(bus.state);
    pop_chk(bus.cmd_ready);
    pop_chk(bus.cycle_count);
    push("halt_in_halted", HALTED);
    issue(CMD_HALT, 8'd0);
    pop_chk(bus.state);
    push("step5_edges", 5);
    push("step5_state", HALTED);
    push("step5_clk_en", 0);
    push("step5_count", cc(5));
    base = edges;
    issue(CMD_STEP, 8'd5);
    wait_state(HALTED);
    pop_chk(edges - base);
    pop_chk(bus.state);
    pop_chk(bus.cpu_clk_en);
    pop_chk(bus.cycle_count);
    push("step0_edges", 1);
    push("step0_count", cc(6));
    base = edges;
    issue(CMD_STEP, 8'd0);
    wait_state(HALTED);
    pop_chk(edges - base);
    pop_chk(bus.cycle_count);
    push("stop_clk_en", 0);
    push("stop_state_same", RUNNING);
    push("stop_state", STOPPED);
    push("stop_edges", 10);
    push("stop_count", cc(16));
    base = edges;
    issue(CMD_RUN, 8'd0);
    wait_edges(base, 10);
    bus.cpu_stop = 1'b1;
    #1;
    pop_chk(bus.cpu_clk_en);
    pop_chk(bus.state);
    @(negedge clk);
    pop_chk(bus.state);
    pop_chk(edges - base);
    pop_chk(bus.cycle_count);
    bus.cpu_stop = 1'b0;
    push("stopped_run_state", STOPPED);
    push("stopped_run_clk_en", 0);
    push("stopped_run_edges", 10);
    issue(CMD_RUN, 8'd0);
    @(negedge clk);
    pop_chk(bus.state);
    pop_chk(bus.cpu_clk_en);
    pop_chk(edges - base);
    push("rst_from_stop_state", RESETTING);
    push("rst_from_stop_count", 0);
    issue(CMD_RESET, 8'd0);
    pop_chk(bus.state);
    pop_chk(bus.cycle_count);
    wait_state(HALTED);
    push("fault_clk_en", 0);
    push("fault_state", FAULT);
    push("fault_err", 2'b01);
    push("fault_count", cc(3));
    push("fault_rst_state", RESETTING);
    push("fault_rst_err", 0);
    base = edges;
    issue(CMD_RUN, 8'd0);
    wait_edges(base, 3);
    bus.cpu_error = 2'b01;
    bus.cpu_stop = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_HALT;
    #1;
    pop_chk(bus.cpu_clk_en);
    @(negedge clk);
    bus.cpu_error = '0;
    bus.cpu_stop = 1'b0;
    bus.cmd_valid = 1'b0;
    pop_chk(bus.state);
    pop_chk(bus.error_latched);
    pop_chk(bus.cycle_count);
    issue(CMD_RESET, 8'd0);
    pop_chk(bus.state);
    pop_chk(bus.error_latched);
    wait_state(HALTED);
    push("halt_step_state", HALTED);
    push("halt_step_edges", 4);
    push("halt_step_count", cc(4));
    base = edges;
    issue(CMD_STEP, 8'd6);
    wait_edges(base, 3);
    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_HALT;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    pop_chk(bus.state);
    pop_chk(edges - base);
    pop_chk(bus.cycle_count);
    push("midrun_rst_cpu_reset", 1);
    push("midrun_rst_state", RESETTING);
    push("midrun_rst_ready", 0);
    push("midrun_rst_count", 0);
    base = edges;
    issue(CMD_RUN, 8'd0);
    wait_edges(base, 2);
    issue(CMD_RESET, 8'd0);
    pop_chk(bus.cpu_reset);
    pop_chk(bus.state);
    pop_chk(bus.cmd_ready);
    pop_chk(bus.cycle_count);
    wait_state(HALTED);
    push("hw_rst_state", RESETTING);
    push("hw_rst_err", 0);
    push("hw_rst_ready", 0);
    push("hw_rst_final_count", 0);
    issue(CMD_RUN, 8'd0);
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_RUN;
    bus.cpu_error = 2'b10;
    @(negedge clk);
    pop_chk(bus.state);
    pop_chk(bus.error_latched);
    pop_chk(bus.cmd_ready);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cpu_error = '0;
    wait_state(HALTED);
    pop_chk(bus.cycle_count);
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter RESET_CYCLES, default 2: number of cycles cpu_reset is held asserted, legal range 1..15.
REQ-002 Parameter CNT_W, default 32: width of cycle_count.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-high controller reset.
REQ-005 cmd_valid  in  1  host command present.
REQ-006 cmd_ready  out  1  controller accepts cmd on this cycle; transfer occurs when cmd_valid && cmd_ready.
REQ-007 cmd  in  2  CtrlCmd: 0 CMD_RESET, 1 CMD_RUN, 2 CMD_STEP, 3 CMD_HALT.
REQ-008 step_count  in  8  number of CPU cycles for CMD_STEP; sampled on acceptance.
REQ-009 cpu_stop  in  1  CPU stop output (EBREAK reached IF).
REQ-010 cpu_error  in  2  CpuError from CPU {decoder, alu}.
REQ-011 cpu_clk_en  out  1  CPU clock enable; the CPU sees a clock edge only when high.
REQ-012 cpu_reset  out  1  reset to CPU and RAM.
REQ-013 state  out  3  current CtrlState, for status/debug.
REQ-014 error_latched  out  2  CpuError captured on entry to FAULT.
REQ-015 cycle_count  out  CNT_W  CPU cycles executed since last CPU reset.

Function
REQ-016 States SHALL be RESETTING, HALTED, RUNNING, STEPPING, STOPPED, FAULT.
REQ-017 RESETTING: cpu_reset=1, cpu_clk_en=1, cmd_ready=0; after RESET_CYCLES cycles -> HALTED.
REQ-018 HALTED: cpu_clk_en=0; CMD_RUN -> RUNNING; CMD_STEP -> STEPPING with step counter loaded from step_count, with 0 treated as 1; CMD_HALT ignored.
REQ-019 RUNNING/STEPPING: cpu_clk_en = !cpu_stop && !(|cpu_error), combinational, so no CPU edge occurs in the cycle a stop or error is visible.
REQ-020 RUNNING/STEPPING: |cpu_error -> FAULT, else cpu_stop -> STOPPED; error has priority over stop, and both have priority over commands.
REQ-021 STEPPING: step counter decrements on each enabled cycle; after the last enabled cycle -> HALTED; exactly step_count CPU edges occur.
REQ-022 CMD_HALT in RUNNING/STEPPING -> HALTED next cycle; the acceptance cycle itself remains enabled.
REQ-023 STOPPED/FAULT: cpu_clk_en=0; only CMD_RESET has effect; CMD_RUN/STEP/HALT are accepted and ignored.
REQ-024 CMD_RESET accepted in any state except RESETTING -> RESETTING.
REQ-025 cmd_ready SHALL be 1 in every state except RESETTING.
REQ-026 error_latched loaded with cpu_error on the FAULT transition; cleared on entry to RESETTING.
REQ-027 cycle_count increments on cycles with cpu_clk_en && !cpu_reset, saturates at all-ones, and clears on entry to RESETTING.

Reset
REQ-028 reset SHALL force state to RESETTING with the reload counter at RESET_CYCLES, step counter 0, error_latched 0, and cycle_count 0; reset dominates commands and CPU inputs.
REQ-029 Output values during reset cycle: cpu_reset=1, cpu_clk_en=1, cmd_ready=0.

Configuration
REQ-030 Macro CPU_CYCLE_COUNTER_EN defined: the cycle_count counter SHALL be implemented per REQ-027.
REQ-031 Macro CPU_CYCLE_COUNTER_EN undefined: cycle_count SHALL be tied to 0 and no counter flops are instantiated; all other behaviour is unchanged.

Structure
REQ-032 CtrlCmd and CtrlState enums SHALL live in types.svh next to CpuError.
REQ-033 The saturating counter SHALL be a sub-module, saturating_counter (width parameter, inc/clear inputs), instantiated only under CPU_CYCLE_COUNTER_EN.

Verification
REQ-034 Assert reset for 1 cycle -> cpu_reset high for exactly 2 cycles, then state=HALTED, cmd_ready=1, cycle_count=0.
REQ-035 CMD_STEP with step_count=5 from HALTED -> cpu_clk_en high for exactly 5 cycles, then HALTED, cycle_count=5; step_count=0 -> exactly 1 cycle.
REQ-036 CMD_RUN, then cpu_stop after 10 enabled cycles -> cpu_clk_en low in the same cycle, state=STOPPED, cycle_count=10; subsequent CMD_RUN is ignored.
REQ-037 RUNNING with cpu_error=2'b01 and cpu_stop asserted in the same cycle -> FAULT, error_latched=01; CMD_RESET -> RESETTING, error_latched=0.
REQ-038 CMD_HALT during STEPPING with 3 steps left -> exactly 1 more enabled cycle, then HALTED; CMD_RESET mid-RUN -> cpu_reset on the next cycle.
REQ-039 Build without CPU_CYCLE_COUNTER_EN and rerun REQ-035 -> identical state and cpu_clk_en trace, cycle_count constantly 0.
